// File: rtl/vram_snoop_if.sv
// vram_snoop_if: signal bundle between the CPU bus pins, the diagnostics
// reader and the vram_snoop block.
//   master : drives CPU bus / control / read address, observes read results
//   slave  : the snoop block itself
// Ports:
//   phi2, cpu_rwb, cpu_address, cpu_data : raw CPU bus, asynchronous to fpga_clk
//   capture_enable, clear_request        : control, fpga_clk domain
//   vram_address, vram_read_clock        : diagnostics read side
//   vram_data, clearing, write_count, vram_dirty : status / read data
interface vram_snoop_if #(
    parameter int ADDR_BITS = 10
);
    logic                 phi2;
    logic                 cpu_rwb;
    logic [15:0]          cpu_address;
    logic [7:0]           cpu_data;
    logic                 capture_enable;
    logic                 clear_request;
    logic [ADDR_BITS-1:0] vram_address;
    logic                 vram_read_clock;
    logic [7:0]           vram_data;
    logic                 clearing;
    logic [15:0]          write_count;
    logic                 vram_dirty;

    modport master (
        output phi2, cpu_rwb, cpu_address, cpu_data,
        output capture_enable, clear_request, vram_address, vram_read_clock,
        input  vram_data, clearing, write_count, vram_dirty
    );

    modport slave (
        input  phi2, cpu_rwb, cpu_address, cpu_data,
        input  capture_enable, clear_request, vram_address, vram_read_clock,
        output vram_data, clearing, write_count, vram_dirty
    );
endinterface

// File: rtl/vram_snoop.sv
// vram_snoop: passively watches CPU writes into the video-RAM window and keeps
// a shadow copy of screen memory in block RAM, readable through a registered
// port by the diagnostics engine. Never drives the CPU bus.
// Ports:
//   fpga_clk   : system clock, rising edge
//   fpga_reset : asynchronous, active-high reset
//   bus        : vram_snoop_if.slave (CPU bus, control, read port, status)
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | normal operation, waiting for clear_request
// CLEARING | zero-sweep of the shadow RAM, one location per free cycle
module vram_snoop #(
    parameter logic [15:0] VRAM_BASE   = 16'h8000,
    parameter int          ADDR_BITS   = 10,
    parameter int          SYNC_STAGES = 2
) (
    input logic         fpga_clk,
    input logic         fpga_reset,
    vram_snoop_if.slave bus
);
    localparam int                   DEPTH = 2 ** ADDR_BITS;
    localparam logic [ADDR_BITS-1:0] LAST  = {ADDR_BITS{1'b1}};

    typedef enum logic {
        ST_IDLE,
        ST_CLEARING
    } state_t;

    logic [SYNC_STAGES-1:0] phi2_sync;
    logic [SYNC_STAGES-1:0] rwb_sync;
    logic                   phi2_s;
    logic                   rwb_s;
    logic                   phi2_d;

    logic [15:0]            sh_addr;
    logic [7:0]             sh_data;
    logic                   sh_rwb;

    logic                   phi2_fall;
    logic                   commit;
    logic                   rd_hit;

    logic [7:0]             mem [DEPTH];
    logic [7:0]             rd_data_q;
    logic                   rd_clk_d;
    logic [15:0]            wr_cnt_q;
    logic                   dirty_q;

    state_t                 state_q, state_n;
    logic [ADDR_BITS-1:0]   clr_addr_q, clr_addr_n;
    logic                   clear_we;

    assign phi2_s = phi2_sync[SYNC_STAGES-1];
    assign rwb_s  = rwb_sync[SYNC_STAGES-1];

    // Shadow registers hold the last phi2-high bus snapshot, so on the fall
    // cycle they describe the completed CPU access.
    assign phi2_fall = phi2_d & ~phi2_s;
    assign commit    = phi2_fall & ~sh_rwb & bus.capture_enable &
                       (sh_addr[15:ADDR_BITS] == VRAM_BASE[15:ADDR_BITS]);

    // Write-first: a commit to the address being read shows up immediately.
    assign rd_hit = commit & (sh_addr[ADDR_BITS-1:0] == bus.vram_address);

    always_ff @(posedge fpga_clk or posedge fpga_reset) begin
        if (fpga_reset) begin
            phi2_sync  <= '0;
            rwb_sync   <= '0;
            phi2_d     <= 1'b0;
            sh_addr    <= '0;
            sh_data    <= '0;
            sh_rwb     <= 1'b0;
            rd_data_q  <= '0;
            rd_clk_d   <= 1'b0;
            wr_cnt_q   <= '0;
            dirty_q    <= 1'b0;
            state_q    <= ST_IDLE;
            clr_addr_q <= '0;
        end else begin
            phi2_sync  <= {phi2_sync[SYNC_STAGES-2:0], bus.phi2};
            rwb_sync   <= {rwb_sync[SYNC_STAGES-2:0], bus.cpu_rwb};
            phi2_d     <= phi2_s;
            if (phi2_s) begin
                sh_addr <= bus.cpu_address;
                sh_data <= bus.cpu_data;
                sh_rwb  <= rwb_s;
            end
            rd_data_q  <= rd_hit ? sh_data : mem[bus.vram_address];
            rd_clk_d   <= bus.vram_read_clock;
            if (commit) begin
                wr_cnt_q <= wr_cnt_q + 16'd1;
                dirty_q  <= 1'b1;
            end else if (bus.vram_read_clock && !rd_clk_d) begin
                dirty_q  <= 1'b0;
            end
            state_q    <= state_n;
            clr_addr_q <= clr_addr_n;
        end
    end

    // Single write port: a commit steals the cycle and the sweep stalls.
    always_ff @(posedge fpga_clk) begin
        if (commit)
            mem[sh_addr[ADDR_BITS-1:0]] <= sh_data;
        else if (clear_we)
            mem[clr_addr_q] <= '0;
    end

    always_comb begin
        state_n    = state_q;
        clr_addr_n = clr_addr_q;
        clear_we   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.clear_request) begin
                    clr_addr_n = '0;
                    state_n    = ST_CLEARING;
                end
            end
            ST_CLEARING: begin
                if (!commit) begin
                    clear_we = 1'b1;
                    if (clr_addr_q == LAST)
                        state_n = ST_IDLE;
                    else
                        clr_addr_n = clr_addr_q + 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign bus.vram_data   = rd_data_q;
    assign bus.clearing    = (state_q == ST_CLEARING);
    assign bus.write_count = wr_cnt_q;
    assign bus.vram_dirty  = dirty_q;
endmodule
